// File: rtl/nibble_serial_add_ctrl_if.sv
// Bundle of request/response and shared-adder signals for the nibble-serial add sequencer.
interface nibble_serial_add_ctrl_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  // Requester side
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;

  // Shared 4-bit adder side
  logic [3:0]   add_s1;
  logic [3:0]   add_s2;
  logic         add_c;
  logic [3:0]   add_sum;
  logic         add_carry;

  // Environment: control unit plus the external adder
  modport master (
    output start, a, b, cin, add_sum, add_carry,
    input  busy, done, result, cout, add_s1, add_s2, add_c
  );

  // The sequencer itself
  modport slave (
    input  start, a, b, cin, add_sum, add_carry,
    output busy, done, result, cout, add_s1, add_s2, add_c
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Sequences a 4*NIBBLES-bit addition through one shared 4-bit adder, LS nibble first.
module nibble_serial_add_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input logic                     clk,
  input logic                     rst,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; RUN leaves after the top nibble
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (idx_q == LastIdx) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: operand capture on accept, nibble/carry collection in RUN
  always_comb begin
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          carry_d  = bus.cin;
          result_d = '0;
          cout_d   = 1'b0;
          idx_d    = '0;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (idx_q == IdxW'(i)) result_d[4*i +: 4] = bus.add_sum;
        end
        carry_d = bus.add_carry;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          cout_d = bus.add_carry;
          idx_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  // Outputs; adder inputs come only from registers so there is no loop through the adder
  always_comb begin
    bus.busy   = (state_q != StIdle);
    bus.done   = (state_q == StDone);
    bus.result = result_q;
    bus.cout   = cout_q;
    bus.add_s1 = 4'h0;
    bus.add_s2 = 4'h0;
    bus.add_c  = 1'b0;
    if (state_q == StRun) begin
      for (int unsigned i = 0; i < NIBBLES; i++) begin
        if (idx_q == IdxW'(i)) begin
          bus.add_s1 = a_q[4*i +: 4];
          bus.add_s2 = b_q[4*i +: 4];
        end
      end
      bus.add_c = carry_q;
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl with a behavioural 4-bit adder.
module tb_nibble_serial_add_ctrl;
  localparam int unsigned NIBBLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] prev_res = 16'h0000;
  logic        prev_cout = 1'b0;
  logic [3:0]  cseq;

  nibble_serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External combinational 4-bit adder
  assign {bus.add_carry, bus.add_sum} = bus.add_s1 + bus.add_s2 + {3'b000, bus.add_c};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'h0);
    check({tag, "_cout"}, 32'(bus.cout), 32'd0);
    check({tag, "_add_s1"}, 32'(bus.add_s1), 32'd0);
    check({tag, "_add_s2"}, 32'(bus.add_s2), 32'd0);
    check({tag, "_add_c"}, 32'(bus.add_c), 32'd0);
  endtask

  // One full operation; poke_busy re-requests during RUN/DONE with other operands
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic [15:0] exp_r, input logic exp_c,
                        input bit poke_busy, output logic [3:0] c_seq);
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = cv;
    bus.start = 1'b1;
    check({tag, "_held_result"}, 32'(bus.result), 32'(prev_res));
    check({tag, "_held_cout"}, 32'(bus.cout), 32'(prev_cout));
    step();
    if (poke_busy) begin
      bus.a     = 16'hAAAA;
      bus.b     = 16'h5555;
      bus.start = 1'b1;
    end else begin
      bus.a     = ~av;
      bus.b     = ~bv;
      bus.cin   = ~cv;
      bus.start = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      check({tag, "_run_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_run_done"}, 32'(bus.done), 32'd0);
      check({tag, "_run_s1"}, 32'(bus.add_s1), 32'(av[4*k +: 4]));
      check({tag, "_run_s2"}, 32'(bus.add_s2), 32'(bv[4*k +: 4]));
      if (k == 0) begin
        check({tag, "_cleared_result"}, 32'(bus.result), 32'h0);
        check({tag, "_first_c"}, 32'(bus.add_c), 32'(cv));
      end
      c_seq[k] = bus.add_c;
      step();
    end
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_done_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_result"}, 32'(bus.result), 32'(exp_r));
    check({tag, "_cout"}, 32'(bus.cout), 32'(exp_c));
    check({tag, "_done_s1"}, 32'(bus.add_s1), 32'd0);
    step();
    bus.start = 1'b0;
    check({tag, "_after_done"}, 32'(bus.done), 32'd0);
    check({tag, "_after_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_after_result"}, 32'(bus.result), 32'(exp_r));
    check({tag, "_after_cout"}, 32'(bus.cout), 32'(exp_c));
    prev_res  = exp_r;
    prev_cout = exp_c;
  endtask

  initial begin
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'hFFFF;
    bus.cin   = 1'b1;
    rst       = 1'b1;

    // Reset held two cycles with start asserted
    step();
    check_idle_zero("rst1");
    step();
    check_idle_zero("rst2");
    bus.start = 1'b0;
    rst       = 1'b0;
    step();
    check_idle_zero("post_rst");

    run_op("nocarry", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, cseq);

    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, cseq);
    check("ripple_cseq", 32'(cseq), 32'hE);

    run_op("max", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, cseq);
    step();
    check("idle_hold_result", 32'(bus.result), 32'hFFFF);
    run_op("msb", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, cseq);

    run_op("busy_start", 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b1, cseq);
    step();
    check("no_queued_busy", 32'(bus.busy), 32'd0);
    run_op("idle_start", 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0, cseq);

    // Reset in the second RUN cycle abandons the operation
    bus.a     = 16'h1111;
    bus.b     = 16'h2222;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("midop_run1_busy", 32'(bus.busy), 32'd1);
    step();
    check("midop_run2_s1", 32'(bus.add_s1), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_zero("midop_rst");
    for (int k = 0; k < 4; k++) begin
      step();
      check("midop_no_done", 32'(bus.done), 32'd0);
    end
    prev_res  = 16'h0000;
    prev_cout = 1'b0;
    run_op("after_abort", 16'h0003, 16'h0004, 1'b1, 16'h0008, 1'b0, 1'b0, cseq);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that performs a (4*NIBBLES)-bit addition with one shared external 4-bit adder (s1, s2, c in; sum, carry out), one nibble per clock, least significant nibble first.
- Latches operands on a start pulse, drives the adder inputs, collects sum nibbles into a result register and chains the carry between cycles.
- Reports completion with a one-cycle done pulse.
- Sits between a requesting control unit and the shared 4-bit adder datapath.

Parameters:
- NIBBLES, 4, operand width in nibbles; legal range 1..16; operand/result width W = 4*NIBBLES.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  W  operand A; sampled on accepted start.
- b  in  W  operand B; sampled on accepted start.
- cin  in  1  carry-in to nibble 0; sampled on accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse (high in DONE).
- result  out  W  registered sum.
- cout  out  1  registered carry out of the top nibble.
- add_s1  out  4  to adder s1.
- add_s2  out  4  to adder s2.
- add_c  out  1  to adder c.
- add_sum  in  4  from adder sum.
- add_carry  in  1  from adder carry.

Behaviour:
- Reset: synchronous, active-high. Clock and reset are one clk and rst, as stated. On a clk edge with rst=1:
  - state=IDLE, nibble index=0, carry register=0.
  - busy=0, done=0, result=0, cout=0.
  - add_s1=0, add_s2=0, add_c=0.
  - rst has priority over every other input.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch a, b and cin (cin becomes the carry register), clear result to 0 and cout to 0, set index=0, go to RUN.
  - Otherwise hold. result and cout keep the last completed value.
- RUN (cycle i = index):
  - add_s1 = a_reg[4i+3:4i], add_s2 = b_reg[4i+3:4i], add_c = carry register. These are combinational from registers only; no path from add_sum or add_carry to the adder inputs.
  - At the edge: result[4i+3:4i] <= add_sum, carry register <= add_carry, index <= index+1.
  - When index = NIBBLES-1: also cout <= add_carry, go to DONE.
- DONE: done=1 for exactly this cycle, busy=1, next state IDLE unconditionally.
- Latency: start accepted at edge E0. Nibble i is computed in cycle i+1 after E0. done is high in cycle NIBBLES+1 after E0, with result and cout already final in that cycle. Next start is accepted no earlier than the edge ending the DONE cycle... correction: start is sampled only in IDLE, so the earliest accepted next start is the first edge after DONE, giving one op per NIBBLES+2 cycles.
- Adder inputs outside RUN: add_s1, add_s2 and add_c are driven 0 in IDLE and DONE.
- start while busy (RUN or DONE): ignored. Operands in flight are unaffected and no request is queued.
- Operand changes after acceptance: changes on a, b or cin after acceptance have no effect.
- Arithmetic: result+cout equals a+b+cin modulo 2^(W+1). Wrap-around is carried only in cout; there is no overflow flag.
- NIBBLES=1: RUN lasts one cycle; the index counter may be a constant 0.
- Reset mid-operation: the operation is abandoned with no done pulse, all outputs return to reset values on the next edge, and the next start is accepted normally.
- Adder model: the external adder is combinational. A settle time within one clk period is a timing requirement, not a protocol requirement.

Test Plan:
(NIBBLES=4; the bench instantiates a behavioural 4-bit adder on add_* ports.)
- Reset: hold rst 2 cycles with start=1 → busy=0, done=0, result=0x0000, cout=0, add_*=0 throughout; no operation starts.
- No carry: a=0x1234, b=0x4321, cin=0, start 1 cycle → busy from next cycle; done high exactly 5 cycles after the start edge with result=0x5555, cout=0; then busy=0.
- Carry ripple: a=0xFFFF, b=0x0001, cin=0 → add_c sequence 0,1,1,1 across RUN cycles; result=0x0000, cout=1.
- Max with carry-in: a=0xFFFF, b=0xFFFF, cin=1 → result=0xFFFF, cout=1. Then a=0x8000, b=0x8000, cin=0 → result=0x0000, cout=1, previous result held until acceptance.
- Start while busy: accept a=0x00F0, b=0x0010, then pulse start with a=0xAAAA, b=0x5555 during RUN and DONE → single done, result=0x0100, cout=0. A start issued in IDLE afterwards yields 0xFFFF.
- Reset mid-op: accept a=0x1111, b=0x2222, assert rst in the 2nd RUN cycle → next cycle IDLE, busy=0, result=0, no done. A new start with a=0x0003, b=0x0004, cin=1 yields result=0x0008, cout=0.
